// File: rtl/sr_ff_checker_if.sv
// Observation and result bundle between an SR flip-flop under check and its checker.
interface sr_ff_checker_if #(
   parameter int unsigned CNT_W = 8
);
   logic             en;
   logic             clr;
   logic             dut_rst;
   logic             S;
   logic             R;
   logic             Q;
   logic             exp_q;
   logic             exp_valid;
   logic             err_pulse;
   logic             err;
   logic             halted;
   logic [CNT_W-1:0] mm_cnt;
   logic [CNT_W-1:0] ill_cnt;
   logic [15:0]      sample_cnt;
   logic [15:0]      first_mm_idx;

   modport master (
      output en, clr, dut_rst, S, R, Q,
      input  exp_q, exp_valid, err_pulse, err, halted,
             mm_cnt, ill_cnt, sample_cnt, first_mm_idx
   );

   modport slave (
      input  en, clr, dut_rst, S, R, Q,
      output exp_q, exp_valid, err_pulse, err, halted,
             mm_cnt, ill_cnt, sample_cnt, first_mm_idx
   );
endinterface

// File: rtl/sr_ff_checker.sv
// Reference-model checker for a synchronous-reset SR flip-flop: predicts Q from the
// commands of the previous sample and flags, counts and timestamps mismatches.
module sr_ff_checker #(
   parameter int unsigned CNT_W       = 8,
   parameter bit          STOP_ON_ERR = 1'b0
) (
   input logic             clk,
   input logic             rst,
   sr_ff_checker_if.slave  chk
);

   typedef enum logic [1:0] {
      UNKNOWN = 2'd0,
      KNOWN   = 2'd1,
      HALT    = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic             exp_q_q, exp_q_d;
   logic             err_q, err_d;
   logic             err_pulse_q, err_pulse_d;
   logic [CNT_W-1:0] mm_cnt_q, mm_cnt_d;
   logic [CNT_W-1:0] ill_cnt_q, ill_cnt_d;
   logic [15:0]      sample_cnt_q, sample_cnt_d;
   logic [15:0]      first_mm_idx_q, first_mm_idx_d;
   logic             mismatch;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q        <= UNKNOWN;
         exp_q_q        <= 1'b0;
         err_q          <= 1'b0;
         err_pulse_q    <= 1'b0;
         mm_cnt_q       <= '0;
         ill_cnt_q      <= '0;
         sample_cnt_q   <= '0;
         first_mm_idx_q <= '0;
      end else begin
         state_q        <= state_d;
         exp_q_q        <= exp_q_d;
         err_q          <= err_d;
         err_pulse_q    <= err_pulse_d;
         mm_cnt_q       <= mm_cnt_d;
         ill_cnt_q      <= ill_cnt_d;
         sample_cnt_q   <= sample_cnt_d;
         first_mm_idx_q <= first_mm_idx_d;
      end
   end

   always_comb begin
      state_d        = state_q;
      exp_q_d        = exp_q_q;
      err_d          = err_q;
      err_pulse_d    = 1'b0;
      mm_cnt_d       = mm_cnt_q;
      ill_cnt_d      = ill_cnt_q;
      sample_cnt_d   = sample_cnt_q;
      first_mm_idx_d = first_mm_idx_q;
      mismatch       = 1'b0;

      if (chk.clr) begin
         // Model (exp_q, KNOWN/UNKNOWN) survives a clear; only HALT is released.
         err_d          = 1'b0;
         mm_cnt_d       = '0;
         ill_cnt_d      = '0;
         sample_cnt_d   = '0;
         first_mm_idx_d = '0;
         if (state_q == HALT) begin
            state_d = UNKNOWN;
         end
      end else if (chk.en && (state_q != HALT)) begin
         mismatch = (state_q == KNOWN) && (chk.Q != exp_q_q);

         if (mismatch) begin
            err_pulse_d = 1'b1;
            err_d       = 1'b1;
            if (mm_cnt_q != '1) begin
               mm_cnt_d = mm_cnt_q + 1'b1;
            end
            if (!err_q) begin
               first_mm_idx_d = sample_cnt_q;
            end
         end

         if (chk.dut_rst) begin
            exp_q_d = 1'b0;
            state_d = KNOWN;
         end else if (chk.S && !chk.R) begin
            exp_q_d = 1'b1;
            state_d = KNOWN;
         end else if (!chk.S && chk.R) begin
            exp_q_d = 1'b0;
            state_d = KNOWN;
         end else if (chk.S && chk.R) begin
            state_d = UNKNOWN;
            if (ill_cnt_q != '1) begin
               ill_cnt_d = ill_cnt_q + 1'b1;
            end
         end

         if (mismatch && STOP_ON_ERR) begin
            state_d = HALT;
         end

         sample_cnt_d = sample_cnt_q + 16'd1;
      end
   end

   assign chk.exp_q        = exp_q_q;
   assign chk.exp_valid    = (state_q == KNOWN);
   assign chk.halted       = (state_q == HALT);
   assign chk.err          = err_q;
   assign chk.err_pulse    = err_pulse_q;
   assign chk.mm_cnt       = mm_cnt_q;
   assign chk.ill_cnt      = ill_cnt_q;
   assign chk.sample_cnt   = sample_cnt_q;
   assign chk.first_mm_idx = first_mm_idx_q;

endmodule

// File: tb/tb_sr_ff_checker.sv
// Scenario bench for sr_ff_checker: one free-running instance and one STOP_ON_ERR instance.
module tb_sr_ff_checker;

   logic clk;
   logic rst_n;

   int n_asserts = 0;
   int n_fail    = 0;

   typedef struct {
      string       tag;
      logic [31:0] v;
      logic [31:0] q;
      logic [31:0] err;
      logic [31:0] pulse;
      logic [31:0] halt;
      logic [31:0] mm;
      logic [31:0] ill;
      logic [31:0] sc;
      logic [31:0] fidx;
   } exp_t;

   exp_t q_exp[$];

   sr_ff_checker_if #(.CNT_W(8)) if0 ();
   sr_ff_checker_if #(.CNT_W(8)) if1 ();

   sr_ff_checker #(.CNT_W(8), .STOP_ON_ERR(1'b0)) u_dut0 (.clk(clk), .rst(rst_n), .chk(if0));
   sr_ff_checker #(.CNT_W(8), .STOP_ON_ERR(1'b1)) u_dut1 (.clk(clk), .rst(rst_n), .chk(if1));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #1ms;
      $display("FAIL watchdog: got timeout, want completion");
      $fatal(1, "watchdog expired");
   end

   function automatic exp_t mk(string tag, logic [31:0] v, logic [31:0] q, logic [31:0] err,
                               logic [31:0] pulse, logic [31:0] halt, logic [31:0] mm,
                               logic [31:0] ill, logic [31:0] sc, logic [31:0] fidx);
      exp_t e;
      e.tag = tag; e.v = v; e.q = q; e.err = err; e.pulse = pulse; e.halt = halt;
      e.mm = mm; e.ill = ill; e.sc = sc; e.fidx = fidx;
      return e;
   endfunction

   // stim bits: {en, clr, dut_rst, S, R, Q}
   task automatic drive0(input logic [5:0] st);
      {if0.en, if0.clr, if0.dut_rst, if0.S, if0.R, if0.Q} = st;
      @(posedge clk);
      #1;
   endtask

   task automatic drive1(input logic [5:0] st);
      {if1.en, if1.clr, if1.dut_rst, if1.S, if1.R, if1.Q} = st;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      exp_t e;
      rst_n = 1'b0;
      {if0.en, if0.clr, if0.dut_rst, if0.S, if0.R, if0.Q} = '0;
      {if1.en, if1.clr, if1.dut_rst, if1.S, if1.R, if1.Q} = '0;
      q_exp.push_back(mk("reset", 0, 0, 0, 0, 0, 0, 0, 0, 0));
      @(posedge clk);
      #1;
      e = q_exp.pop_front();
      n_asserts++; if (32'(if0.exp_valid) !== e.v) begin n_fail++; $display("FAIL %s exp_valid: got %0b want %0d", e.tag, if0.exp_valid, e.v); end
      n_asserts++; if (32'(if0.exp_q) !== e.q) begin n_fail++; $display("FAIL %s exp_q: got %0b want %0d", e.tag, if0.exp_q, e.q); end
      n_asserts++; if (32'(if0.err) !== e.err) begin n_fail++; $display("FAIL %s err: got %0b want %0d", e.tag, if0.err, e.err); end
      n_asserts++; if (32'(if0.err_pulse) !== e.pulse) begin n_fail++; $display("FAIL %s err_pulse: got %0b want %0d", e.tag, if0.err_pulse, e.pulse); end
      n_asserts++; if (32'(if1.halted) !== e.halt) begin n_fail++; $display("FAIL %s halted: got %0b want %0d", e.tag, if1.halted, e.halt); end
      n_asserts++; if (32'(if0.mm_cnt) !== e.mm) begin n_fail++; $display("FAIL %s mm_cnt: got %0d want %0d", e.tag, if0.mm_cnt, e.mm); end
      n_asserts++; if (32'(if0.ill_cnt) !== e.ill) begin n_fail++; $display("FAIL %s ill_cnt: got %0d want %0d", e.tag, if0.ill_cnt, e.ill); end
      n_asserts++; if (32'(if0.sample_cnt) !== e.sc) begin n_fail++; $display("FAIL %s sample_cnt: got %0d want %0d", e.tag, if0.sample_cnt, e.sc); end
      n_asserts++; if (32'(if0.first_mm_idx) !== e.fidx) begin n_fail++; $display("FAIL %s first_mm_idx: got %0d want %0d", e.tag, if0.first_mm_idx, e.fidx); end
      rst_n = 1'b1;
   endtask

   task automatic check_step0(input logic [5:0] st, input exp_t ex);
      exp_t e;
      q_exp.push_back(ex);
      drive0(st);
      e = q_exp.pop_front();
      n_asserts++; if (32'(if0.exp_valid) !== e.v) begin n_fail++; $display("FAIL %s exp_valid: got %0b want %0d", e.tag, if0.exp_valid, e.v); end
      if (e.v[0]) begin
         n_asserts++; if (32'(if0.exp_q) !== e.q) begin n_fail++; $display("FAIL %s exp_q: got %0b want %0d", e.tag, if0.exp_q, e.q); end
      end
      n_asserts++; if (32'(if0.err) !== e.err) begin n_fail++; $display("FAIL %s err: got %0b want %0d", e.tag, if0.err, e.err); end
      n_asserts++; if (32'(if0.err_pulse) !== e.pulse) begin n_fail++; $display("FAIL %s err_pulse: got %0b want %0d", e.tag, if0.err_pulse, e.pulse); end
      n_asserts++; if (32'(if0.halted) !== e.halt) begin n_fail++; $display("FAIL %s halted: got %0b want %0d", e.tag, if0.halted, e.halt); end
      n_asserts++; if (32'(if0.mm_cnt) !== e.mm) begin n_fail++; $display("FAIL %s mm_cnt: got %0d want %0d", e.tag, if0.mm_cnt, e.mm); end
      n_asserts++; if (32'(if0.ill_cnt) !== e.ill) begin n_fail++; $display("FAIL %s ill_cnt: got %0d want %0d", e.tag, if0.ill_cnt, e.ill); end
      n_asserts++; if (32'(if0.sample_cnt) !== e.sc) begin n_fail++; $display("FAIL %s sample_cnt: got %0d want %0d", e.tag, if0.sample_cnt, e.sc); end
      n_asserts++; if (32'(if0.first_mm_idx) !== e.fidx) begin n_fail++; $display("FAIL %s first_mm_idx: got %0d want %0d", e.tag, if0.first_mm_idx, e.fidx); end
   endtask

   task automatic test_unknown();
      for (int i = 1; i <= 3; i++)
         check_step0(6'b10000x, mk($sformatf("unknown%0d", i), 0, 0, 0, 0, 0, 0, 0, i, 0));
   endtask

   task automatic test_define();
      check_step0(6'b10100x, mk("define.rst",  1, 0, 0, 0, 0, 0, 0, 4, 0));
      check_step0(6'b100100, mk("define.set",  1, 1, 0, 0, 0, 0, 0, 5, 0));
      check_step0(6'b100001, mk("define.hold", 1, 1, 0, 0, 0, 0, 0, 6, 0));
   endtask

   task automatic test_mismatch();
      check_step0(6'b100000, mk("mismatch1",   1, 1, 1, 1, 0, 1, 0, 7, 6));
      check_step0(6'b100000, mk("mismatch2",   1, 1, 1, 1, 0, 2, 0, 8, 6));
      check_step0(6'b000001, mk("mismatch.en0", 1, 1, 1, 0, 0, 2, 0, 8, 6));
   endtask

   task automatic test_illegal();
      check_step0(6'b100111, mk("illegal.sr11",  0, 0, 1, 0, 0, 2, 1, 9, 6));
      check_step0(6'b100010, mk("illegal.reset", 1, 0, 1, 0, 0, 2, 1, 10, 6));
      check_step0(6'b101110, mk("illegal.rstwin", 1, 0, 1, 0, 0, 2, 1, 11, 6));
   endtask

   task automatic test_clr();
      check_step0(6'b110101, mk("clr",       1, 0, 0, 0, 0, 0, 0, 0, 0));
      check_step0(6'b100100, mk("clr.after", 1, 1, 0, 0, 0, 0, 0, 1, 0));
   endtask

   task automatic test_saturation();
      exp_t e;
      for (int i = 1; i <= 258; i++) begin
         q_exp.push_back(mk($sformatf("sat%0d", i), 1, 1, 1, 1, 0, (i < 255) ? i : 255, 0, 1 + i, 1));
         drive0(6'b100000);
         e = q_exp.pop_front();
         n_asserts++; if (32'(if0.mm_cnt) !== e.mm) begin n_fail++; $display("FAIL %s mm_cnt: got %0d want %0d", e.tag, if0.mm_cnt, e.mm); end
         n_asserts++; if (32'(if0.err_pulse) !== e.pulse) begin n_fail++; $display("FAIL %s err_pulse: got %0b want %0d", e.tag, if0.err_pulse, e.pulse); end
         n_asserts++; if (32'(if0.sample_cnt) !== e.sc) begin n_fail++; $display("FAIL %s sample_cnt: got %0d want %0d", e.tag, if0.sample_cnt, e.sc); end
         n_asserts++; if (32'(if0.first_mm_idx) !== e.fidx) begin n_fail++; $display("FAIL %s first_mm_idx: got %0d want %0d", e.tag, if0.first_mm_idx, e.fidx); end
      end
   endtask

   task automatic check_step1(input logic [5:0] st, input exp_t ex);
      exp_t e;
      q_exp.push_back(ex);
      drive1(st);
      e = q_exp.pop_front();
      n_asserts++; if (32'(if1.exp_valid) !== e.v) begin n_fail++; $display("FAIL %s exp_valid: got %0b want %0d", e.tag, if1.exp_valid, e.v); end
      n_asserts++; if (32'(if1.err) !== e.err) begin n_fail++; $display("FAIL %s err: got %0b want %0d", e.tag, if1.err, e.err); end
      n_asserts++; if (32'(if1.err_pulse) !== e.pulse) begin n_fail++; $display("FAIL %s err_pulse: got %0b want %0d", e.tag, if1.err_pulse, e.pulse); end
      n_asserts++; if (32'(if1.halted) !== e.halt) begin n_fail++; $display("FAIL %s halted: got %0b want %0d", e.tag, if1.halted, e.halt); end
      n_asserts++; if (32'(if1.mm_cnt) !== e.mm) begin n_fail++; $display("FAIL %s mm_cnt: got %0d want %0d", e.tag, if1.mm_cnt, e.mm); end
      n_asserts++; if (32'(if1.ill_cnt) !== e.ill) begin n_fail++; $display("FAIL %s ill_cnt: got %0d want %0d", e.tag, if1.ill_cnt, e.ill); end
      n_asserts++; if (32'(if1.sample_cnt) !== e.sc) begin n_fail++; $display("FAIL %s sample_cnt: got %0d want %0d", e.tag, if1.sample_cnt, e.sc); end
      n_asserts++; if (32'(if1.first_mm_idx) !== e.fidx) begin n_fail++; $display("FAIL %s first_mm_idx: got %0d want %0d", e.tag, if1.first_mm_idx, e.fidx); end
   endtask

   task automatic test_halt();
      if0.en = 1'b0;
      check_step1(6'b10100x, mk("halt.define", 1, 0, 0, 0, 0, 0, 0, 1, 0));
      check_step1(6'b100001, mk("halt.mismatch", 0, 0, 1, 1, 1, 1, 0, 2, 1));
      for (int i = 1; i <= 5; i++)
         check_step1(6'b100111, mk($sformatf("halt.frozen%0d", i), 0, 0, 1, 0, 1, 1, 0, 2, 1));
      check_step1(6'b110000, mk("halt.clr",    0, 0, 0, 0, 0, 0, 0, 0, 0));
      check_step1(6'b100011, mk("halt.resume", 1, 0, 0, 0, 0, 0, 0, 1, 0));
      if1.en = 1'b0;
   endtask

   task automatic test_async_reset();
      exp_t e;
      #2;
      q_exp.push_back(mk("arst", 0, 0, 0, 0, 0, 0, 0, 0, 0));
      rst_n = 1'b0;
      #1;
      e = q_exp.pop_front();
      n_asserts++; if (32'(if0.exp_valid) !== e.v) begin n_fail++; $display("FAIL %s exp_valid: got %0b want %0d", e.tag, if0.exp_valid, e.v); end
      n_asserts++; if (32'(if0.exp_q) !== e.q) begin n_fail++; $display("FAIL %s exp_q: got %0b want %0d", e.tag, if0.exp_q, e.q); end
      n_asserts++; if (32'(if0.err) !== e.err) begin n_fail++; $display("FAIL %s err: got %0b want %0d", e.tag, if0.err, e.err); end
      n_asserts++; if (32'(if0.mm_cnt) !== e.mm) begin n_fail++; $display("FAIL %s mm_cnt: got %0d want %0d", e.tag, if0.mm_cnt, e.mm); end
      n_asserts++; if (32'(if0.sample_cnt) !== e.sc) begin n_fail++; $display("FAIL %s sample_cnt: got %0d want %0d", e.tag, if0.sample_cnt, e.sc); end
      n_asserts++; if (32'(if0.first_mm_idx) !== e.fidx) begin n_fail++; $display("FAIL %s first_mm_idx: got %0d want %0d", e.tag, if0.first_mm_idx, e.fidx); end
      n_asserts++; if (32'(if1.exp_valid) !== e.v) begin n_fail++; $display("FAIL %s dut1 exp_valid: got %0b want %0d", e.tag, if1.exp_valid, e.v); end
      @(negedge clk);
      rst_n = 1'b1;
      check_step0(6'b100001, mk("arst.post1", 0, 0, 0, 0, 0, 0, 0, 1, 0));
      check_step0(6'b100010, mk("arst.post2", 1, 0, 0, 0, 0, 0, 0, 2, 0));
   endtask

   initial begin
      test_reset();
      test_unknown();
      test_define();
      test_mismatch();
      test_illegal();
      test_clr();
      test_saturation();
      test_halt();
      test_async_reset();
      $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
      $finish;
   end

endmodule

// File: doc/sr_ff_checker.md
SR_FF_CHECKER -- requirements
Module: sr_ff_checker

Interface
REQ-001 Parameter CNT_W, default 8, width of the mismatch and illegal-command counters.
REQ-002 Parameter STOP_ON_ERR, default 0; when 1, the checker freezes after the first mismatch.
REQ-003 clk  input  1  sampling clock, shared with the flip-flop under check; all state updates on the rising edge.
REQ-004 rst  input  1  asynchronous, active-low reset of the checker.
REQ-005 en  input  1  sample qualifier; when 0, no state, counter or output changes except err_pulse, which clears.
REQ-006 clr  input  1  synchronous clear of counters, err and first_mm_idx; the reference model is preserved.
REQ-007 dut_rst  input  1  observed synchronous active-high reset of the flip-flop under check.
REQ-008 S, R  input  1 each  observed set and reset commands driven to the flip-flop under check.
REQ-009 Q  input  1  observed flip-flop output.
REQ-010 exp_q, exp_valid  output  1 each  model's expected Q and its validity.
REQ-011 err_pulse  output  1  one-cycle mismatch indication.
REQ-012 err  output  1  sticky error flag.
REQ-013 mm_cnt, ill_cnt  output  CNT_W each  mismatch count and S=R=1 command count.
REQ-014 sample_cnt, first_mm_idx  output  16 each  enabled-sample index and the index of the first mismatch.
REQ-015 halted  output  1  high when in state HALT.

Function
REQ-016 The checker shall use FSM states UNKNOWN (exp_valid=0), KNOWN (exp_valid=1) and HALT.
REQ-017 On each rising edge with en=1 in UNKNOWN or KNOWN, the checker shall first compare, then update the model, then increment sample_cnt.
REQ-018 Compare: in KNOWN, Q != exp_q shall set err_pulse=1 for the next cycle, set err, and increment mm_cnt, which saturates at 2^CNT_W-1.
REQ-019 If err was 0 before a mismatch, first_mm_idx shall capture the current sample_cnt value, before the increment.
REQ-020 Model update priority: dut_rst=1 -> exp_q=0, KNOWN; else S=1,R=0 -> exp_q=1, KNOWN; else S=0,R=1 -> exp_q=0, KNOWN.
REQ-021 Model update, remaining cases: S=0,R=0 -> hold exp_q and state; S=1,R=1 -> UNKNOWN with ill_cnt incremented (saturating).
REQ-022 The model shall never resynchronise to Q; after a mismatch under hold commands, mismatches repeat every sample.
REQ-023 Latency: the command sampled at edge k shall be checked against Q sampled at edge k+1; err_pulse is visible after edge k+1.
REQ-024 With STOP_ON_ERR=1, a mismatch shall move the FSM to HALT; in HALT, only clr and rst act, and halted=1.
REQ-025 clr=1 shall zero mm_cnt, ill_cnt, sample_cnt, first_mm_idx, err and err_pulse, and shall move HALT to UNKNOWN; KNOWN and UNKNOWN are kept.
REQ-026 clr overrides en: a clr cycle performs no compare and no model update.
REQ-027 sample_cnt shall wrap from 65535 to 0.
REQ-028 When dut_rst and S=R=1 are sampled together, dut_rst shall win, ill_cnt shall not increment, and the state shall be KNOWN with exp_q=0.

Reset
REQ-029 rst=0 shall immediately force state UNKNOWN, exp_q=0, exp_valid=0, err=0, err_pulse=0, halted=0, and all counters and first_mm_idx to 0, regardless of clk.
REQ-030 Reset asserted mid-sequence shall discard the model; the first compare after release requires a defining command.

Verification
REQ-031 After reset, en=1 with S=0,R=0 and Q=X for 3 cycles -> exp_valid=0, err=0, sample_cnt=3.
REQ-032 Drive dut_rst=1, then S=1,R=0, with Q following correctly -> exp_q=1, mm_cnt=0, err=0.
REQ-033 From KNOWN with exp_q=1, drive S=0,R=0 and force Q=0 for 2 samples -> err_pulse high twice, mm_cnt=2, first_mm_idx equals the index of the first compare.
REQ-034 Drive S=1,R=1, then Q=0 -> no mismatch, ill_cnt=1, exp_valid=0; then S=0,R=1 -> KNOWN with exp_q=0.
REQ-035 With STOP_ON_ERR=1, after one mismatch -> halted=1 and counters frozen for 5 cycles; clr -> halted=0 and all counters 0.
REQ-036 Assert rst low asynchronously between edges while in KNOWN -> outputs reach reset values before the next edge, and sample_cnt restarts from 0.
